mac_result_packer: RTL and testbench

Output buffer that sits directly downstream of `mac` and drains its per-cycle results onto a 16-bit valid/ready stream. FP16 results pass through one per word. INT8 results are packed two per word, with an explicit flush for an odd trailing byte. A small FIFO absorbs back-pressure from the consumer, so the MAC's producer logic stalls via `in_ready` and results are never dropped.

---
 rtl/mac_result_packer.sv | 151 +++++++++++++++
 tb/tb_mac_result_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_packer.sv
// -----------------------------------------------------------------------------
// mac_result_packer
//
// Output buffer behind the MAC datapath. It converts per-cycle MAC results
// into a 16-bit valid/ready word stream:
//   * FP16 results pass through, one result per word (fmt = 1).
//   * INT8 results are packed two per word, with the first byte in the low
//     half (fmt = 0). An odd trailing byte is emitted on its own
//     (half = 1, high byte zero). This happens on a flush request or when
//     the stream switches to FP16.
//   * A DEPTH-word FIFO absorbs consumer back-pressure. The producer is
//     stalled through in_ready_o, so no result is ever dropped.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   fp_sel_i       format of the current beat: 1 = FP16, 0 = INT8
//   in_valid_i     result_int8_i / result_fp16_i hold a valid result
//   in_ready_o     beat accepted this cycle (never depends on out_ready_i)
//   result_int8_i  INT8 result
//   result_fp16_i  FP16 result
//   flush_i        level request to emit a pending odd INT8 byte
//   out_valid_o    out_data_o holds the FIFO head word
//   out_ready_i    consumer takes the head word this cycle
//   out_data_o     head word, zero when out_valid_o is low
//   out_fmt_o      head word format: 1 = FP16, 0 = packed INT8
//   out_half_o     head INT8 word carries only its low byte
//   pend_valid_o   one INT8 byte is waiting in the pack register
//   count_o        FIFO occupancy in words
// -----------------------------------------------------------------------------
module mac_result_packer #(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fp_sel_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [7:0]                   result_int8_i,
    input  logic [15:0]                  result_fp16_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [15:0]                  out_data_o,
    output logic                         out_fmt_o,
    output logic                         out_half_o,
    output logic                         pend_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Stored word layout: {half, fmt, data[15:0]}
    logic [17:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_byte_q, pend_byte_d;

    logic             full;
    logic             empty;
    logic             force_emit;
    logic             accept;
    logic             push;
    logic             pop;
    logic [17:0]      push_word;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);

        // A held byte must leave before an FP16 beat or on flush. That costs
        // one push slot, so the incoming beat is stalled in the same cycle.
        force_emit = pend_valid_q && !full && (flush_i || fp_sel_i);
        in_ready_o = !full && !(pend_valid_q && (flush_i || fp_sel_i));
        accept     = in_valid_i && in_ready_o;
        pop        = !empty && out_ready_i;

        push         = 1'b0;
        push_word    = '0;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;

        if (force_emit) begin
            push         = 1'b1;
            push_word    = {1'b1, 1'b0, 8'h00, pend_byte_q};
            pend_valid_d = 1'b0;
        end else if (accept) begin
            if (fp_sel_i) begin
                push      = 1'b1;
                push_word = {1'b0, 1'b1, result_fp16_i};
            end else if (pend_valid_q) begin
                push         = 1'b1;
                push_word    = {1'b0, 1'b0, result_int8_i, pend_byte_q};
                pend_valid_d = 1'b0;
            end else begin
                pend_byte_d  = result_int8_i;
                pend_valid_d = 1'b1;
            end
        end

        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Storage is data only. Its contents are meaningless unless marked
    // valid by the control state, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
        pend_byte_q <= pend_byte_d;
    end

    always_comb begin
        out_valid_o  = !empty;
        out_data_o   = 16'h0000;
        out_fmt_o    = 1'b0;
        out_half_o   = 1'b0;
        if (!empty) begin
            {out_half_o, out_fmt_o, out_data_o} = mem_q[rd_ptr_q];
        end
        pend_valid_o = pend_valid_q;
        count_o      = count_q;
    end

endmodule

// File: tb/tb_mac_result_packer.sv
`timescale 1ns/100ps
module tb_mac_result_packer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fp_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  r8;
    logic [15:0] r16;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_fmt;
    logic        out_half;
    logic        pend_valid;
    logic [$clog2(DEPTH+1)-1:0] count;

    mac_result_packer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fp_sel_i      (fp_sel),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .result_int8_i (r8),
        .result_fp16_i (r16),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_fmt_o     (out_fmt),
        .out_half_o    (out_half),
        .pend_valid_o  (pend_valid),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: expected words in output order ({half, fmt, data}),
    // the pending byte, and occupancy at the start of the current cycle.
    logic [17:0] exp_q [$];
    logic        pend_m   = 1'b0;
    logic [7:0]  pbyte_m  = 8'h00;
    int          occ      = 0;
    logic        last_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy, output validity, and in-order word comparison.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
            occ = exp_q.size();
            chk("count", 32'(count), 32'(occ));
            chk("out_valid", 32'(out_valid), 32'(occ != 0));
            if (!out_valid) begin
                chk("idle_out", {14'd0, out_half, out_fmt, out_data}, 32'd0);
            end else if (out_ready && exp_q.size() > 0) begin
                chk("word", {14'd0, out_half, out_fmt, out_data}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    // Model step: apply the packing rules to this cycle's inputs.
    initial forever begin
        @(negedge clk);
        #2;
        last_acc = 1'b0;
        if (!rst) begin
            logic is_full, exp_ir;
            is_full = (occ == DEPTH);
            exp_ir  = !is_full && !(pend_m && (flush || fp_sel));
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("pend_valid", 32'(pend_valid), 32'(pend_m));
            last_acc = in_valid && exp_ir;
            if (pend_m && !is_full && (flush || fp_sel)) begin
                exp_q.push_back({2'b10, 8'h00, pbyte_m});
                pend_m = 1'b0;
            end else if (last_acc) begin
                if (fp_sel) begin
                    exp_q.push_back({2'b01, r16});
                end else if (pend_m) begin
                    exp_q.push_back({2'b00, r8, pbyte_m});
                    pend_m = 1'b0;
                end else begin
                    pbyte_m = r8;
                    pend_m  = 1'b1;
                end
            end
        end
    end

    task automatic beat(input logic v, input logic fp, input logic [7:0] b,
                        input logic [15:0] w, input logic fl, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        fp_sel    = fp;
        r8        = b;
        r16       = w;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, ordy);
    endtask

    // Present a beat and keep it until it is accepted (bounded).
    task automatic hold(input logic fp, input logic [7:0] b, input logic [15:0] w, input logic ordy);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            beat(1'b1, fp, b, w, 1'b0, ordy);
            #3;
            done = last_acc;
        end
        chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_fmt", 32'(out_fmt), 32'd0);
        chk("rst_out_half", 32'(out_half), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pend", 32'(pend_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; fp_sel = 1'b0; r8 = 8'h00; r16 = 16'h0000;
        flush = 1'b0; out_ready = 1'b0;
        #5;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // FP16 stream
        hold(1'b1, 8'h00, 16'h3C00, 1'b1);
        hold(1'b1, 8'h00, 16'h4000, 1'b1);
        hold(1'b1, 8'h00, 16'hC200, 1'b1);
        idle(3, 1'b1);

        // INT8 pack
        hold(1'b0, 8'h20, 16'h0000, 1'b1);
        hold(1'b0, 8'h24, 16'h0000, 1'b1);
        idle(3, 1'b1);

        // Flush of a lone byte
        hold(1'b0, 8'h7F, 16'h0000, 1'b1);
        beat(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Mode switch forces the pending byte out, then the FP16 beat goes in
        hold(1'b0, 8'h34, 16'h0000, 1'b1);
        hold(1'b1, 8'h00, 16'h5555, 1'b1);
        idle(3, 1'b1);

        // Back-pressure: fill the FIFO, hold a 5th word, then release
        hold(1'b1, 8'h00, 16'h1111, 1'b0);
        hold(1'b1, 8'h00, 16'h2222, 1'b0);
        hold(1'b1, 8'h00, 16'h3333, 1'b0);
        hold(1'b1, 8'h00, 16'h4444, 1'b0);
        beat(1'b1, 1'b1, 8'h00, 16'h5A5A, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 8'h00, 16'h5A5A, 1'b0, 1'b0);
        hold(1'b1, 8'h00, 16'h5A5A, 1'b1);
        idle(8, 1'b1);

        // Asynchronous reset mid-stream with three words stored
        hold(1'b1, 8'h00, 16'hAAAA, 1'b0);
        hold(1'b0, 8'h01, 16'h0000, 1'b0);
        hold(1'b0, 8'h02, 16'h0000, 1'b0);
        hold(1'b1, 8'h00, 16'hBBBB, 1'b0);
        hold(1'b0, 8'h03, 16'h0000, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        #5;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        pend_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with varying back-pressure
        for (int i = 0; i < 1500; i++) begin
            int ordy_pct;
            ordy_pct = ((i / 200) % 2 == 0) ? 80 : 30;
            beat($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 8'($urandom),
                 16'($urandom),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) < ordy_pct);
        end

        idle(12, 1'b1);
        #3;
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
